// File: rtl/syscall_console.sv
// -----------------------------------------------------------------------------
// syscall_console
// Console output engine for the MIPS core. On a syscall it decodes v0, turns
// the request into ASCII bytes (decimal print_int, NUL-terminated print_string
// fetched word by word from data memory, print_char) and queues them in an
// internal FIFO drained over a valid/ready port. v0 == 10 latches a sticky
// exit request. The core is stalled until the whole request has been queued.
//
// Optional feature: define SYSCALL_NEWLINE_EN to append 0x0A after every
// print_int / print_string / print_char payload.
//
// Parameters:
//   FIFO_DEPTH  output character FIFO entries (power of 2, >= 2)
//   MAX_STR     maximum characters emitted for one print_string
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   syscall    in   syscall instruction in flight
//   v0         in   service code
//   a0         in   argument
//   stall      out  hold PC / suppress writes
//   memAddr    out  word address to data memory
//   memRead    out  read strobe, memData valid the following cycle
//   memData    in   read word, little-endian bytes
//   charOut    out  byte at the FIFO head (0 when empty)
//   charValid  out  FIFO non-empty
//   charReady  in   consumer accepts charOut on this edge
//   exitReq    out  sticky exit request
// -----------------------------------------------------------------------------
module syscall_console #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_STR    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic [31:0] memAddr,
  output logic        memRead,
  input  logic [31:0] memData,
  output logic [7:0]  charOut,
  output logic        charValid,
  input  logic        charReady,
  output logic        exitReq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef SYSCALL_NEWLINE_EN
  typedef enum logic [3:0] {
    IDLE, INT_SIGN, INT_DIGIT, STR_REQ, STR_WAIT, STR_EMIT, CHAR, NL, DONE
  } state_t;
  localparam state_t S_TAIL = NL;
`else
  typedef enum logic [3:0] {
    IDLE, INT_SIGN, INT_DIGIT, STR_REQ, STR_WAIT, STR_EMIT, CHAR, DONE
  } state_t;
  localparam state_t S_TAIL = DONE;
`endif

  // FSM registers
  state_t      r_state;
  logic [31:0] r_arg;      // a0 captured when the syscall is accepted
  logic [31:0] r_mag;      // remaining magnitude for print_int
  logic [3:0]  r_p;        // current decimal position (10^p)
  logic [3:0]  r_d;        // digit being accumulated
  logic        r_emitted;  // a digit has been emitted (suppresses leading zeros)
  logic [31:0] r_off;      // print_string byte offset
  logic [31:0] r_word;     // latched memory word
  logic        r_exit;

  // FIFO registers
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic [31:0] w_byteAddr;
  logic [7:0]  w_strByte;
  logic [31:0] w_pow;
  logic        w_digitGe;
  logic        w_strEnd;
  logic        w_full;
  logic        w_pop;
  logic        w_pushReq;
  logic [7:0]  w_pushData;
  logic        w_push;
  logic        w_hold;
  logic        w_svcValid;

  function automatic logic [31:0] f_pow10(input logic [3:0] p);
    case (p)
      4'd0:    return 32'd1;
      4'd1:    return 32'd10;
      4'd2:    return 32'd100;
      4'd3:    return 32'd1000;
      4'd4:    return 32'd10000;
      4'd5:    return 32'd100000;
      4'd6:    return 32'd1000000;
      4'd7:    return 32'd10000000;
      4'd8:    return 32'd100000000;
      4'd9:    return 32'd1000000000;
      default: return 32'd1;
    endcase
  endfunction

  always_comb begin
    w_byteAddr = r_arg + r_off;
    w_strByte  = r_word[{w_byteAddr[1:0], 3'b000} +: 8];
    w_pow      = f_pow10(r_p);
    w_digitGe  = (r_mag >= w_pow);
    w_strEnd   = (w_strByte == 8'h00) || (r_off == 32'(MAX_STR));
    w_full     = (r_count == CW'(FIFO_DEPTH));
    w_pop      = (r_count != '0) && charReady;
    w_svcValid = (v0 == 32'd1) || (v0 == 32'd4) || (v0 == 32'd10) || (v0 == 32'd11);
  end

  // Byte the current state wants to queue this cycle
  always_comb begin
    w_pushReq  = 1'b0;
    w_pushData = '0;
    case (r_state)
      INT_SIGN: begin
        if (r_arg[31]) begin
          w_pushReq  = 1'b1;
          w_pushData = 8'h2D;
        end
      end
      INT_DIGIT: begin
        if (!w_digitGe && (r_d != 4'd0 || r_emitted || r_p == 4'd0)) begin
          w_pushReq  = 1'b1;
          w_pushData = 8'h30 + {4'b0000, r_d};
        end
      end
      STR_EMIT: begin
        if (!w_strEnd) begin
          w_pushReq  = 1'b1;
          w_pushData = w_strByte;
        end
      end
      CHAR: begin
        w_pushReq  = 1'b1;
        w_pushData = r_arg[7:0];
      end
`ifdef SYSCALL_NEWLINE_EN
      NL: begin
        w_pushReq  = 1'b1;
        w_pushData = 8'h0A;
      end
`endif
      default: ;
    endcase
    // Fullness is judged before any same-cycle pop
    w_push = w_pushReq && !w_full;
    w_hold = w_pushReq && w_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_arg     <= '0;
      r_mag     <= '0;
      r_p       <= '0;
      r_d       <= '0;
      r_emitted <= 1'b0;
      r_off     <= '0;
      r_word    <= '0;
      r_exit    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (syscall) begin
            r_arg <= a0;
            case (v0)
              32'd1:  r_state <= INT_SIGN;
              32'd4: begin
                r_off   <= '0;
                r_state <= STR_REQ;
              end
              32'd11: r_state <= CHAR;
              32'd10: begin
                r_exit  <= 1'b1;
                r_state <= DONE;
              end
              default: ;
            endcase
          end
        end
        INT_SIGN: begin
          if (!w_hold) begin
            r_mag     <= r_arg[31] ? (32'd0 - r_arg) : r_arg;
            r_p       <= 4'd9;
            r_d       <= '0;
            r_emitted <= 1'b0;
            r_state   <= INT_DIGIT;
          end
        end
        INT_DIGIT: begin
          // Repeated subtraction: one subtract or one digit completion per cycle
          if (w_digitGe) begin
            r_mag <= r_mag - w_pow;
            r_d   <= r_d + 4'd1;
          end else if (!w_hold) begin
            if (w_pushReq) r_emitted <= 1'b1;
            r_d <= '0;
            if (r_p == 4'd0) r_state <= S_TAIL;
            else             r_p     <= r_p - 4'd1;
          end
        end
        STR_REQ:  r_state <= STR_WAIT;
        STR_WAIT: begin
          r_word  <= memData;
          r_state <= STR_EMIT;
        end
        STR_EMIT: begin
          if (w_strEnd) begin
            r_state <= S_TAIL;
          end else if (!w_hold) begin
            r_off <= r_off + 32'd1;
            if (w_byteAddr[1:0] == 2'b11) r_state <= STR_REQ;
          end
        end
        CHAR: begin
          if (!w_hold) r_state <= S_TAIL;
        end
`ifdef SYSCALL_NEWLINE_EN
        NL: begin
          if (!w_hold) r_state <= DONE;
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; charOut is gated while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_pushData;
  end

  always_comb begin
    charValid = (r_count != '0);
    charOut   = charValid ? r_mem[r_rd] : '0;
    memRead   = (r_state == STR_REQ);
    memAddr   = memRead ? {2'b00, w_byteAddr[31:2]} : '0;
    exitReq   = r_exit;
    stall     = ((r_state != IDLE) && (r_state != DONE)) ||
                ((r_state == IDLE) && syscall && w_svcValid);
  end

endmodule

// File: tb/tb_syscall_console.sv
// -----------------------------------------------------------------------------
// tb_syscall_console
// Self-checking bench for syscall_console: directed and randomized syscalls
// compared against a byte-level reference (decimal text via $sformatf, string
// walk over a byte-addressed memory image). Honours SYSCALL_NEWLINE_EN.
// -----------------------------------------------------------------------------
module tb_syscall_console;

`ifdef SYSCALL_NEWLINE_EN
  localparam int NLC = 1;
`else
  localparam int NLC = 0;
`endif
  localparam int MAXS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall;
  logic [31:0] v0, a0;
  logic        stall;
  logic [31:0] memAddr;
  logic        memRead;
  logic [31:0] memData = 32'hDEADBEEF;
  logic [7:0]  charOut;
  logic        charValid;
  logic        charReady;
  logic        exitReq;

  always #5 clk = ~clk;

  syscall_console #(.FIFO_DEPTH(8), .MAX_STR(MAXS)) dut (
    .clk(clk), .reset(reset), .syscall(syscall), .v0(v0), .a0(a0),
    .stall(stall), .memAddr(memAddr), .memRead(memRead), .memData(memData),
    .charOut(charOut), .charValid(charValid), .charReady(charReady),
    .exitReq(exitReq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  bmem [1024];
  logic [7:0]  rx[$];
  logic [7:0]  exp_q[$];
  logic [31:0] rd_addrs[$];
  logic        p_rd = 1'b0;
  logic [31:0] p_addr = '0;

  // Memory model: one-cycle read latency, garbage when no read was issued
  always @(negedge clk) begin
    p_rd   = memRead;
    p_addr = memAddr;
    if (memRead) rd_addrs.push_back(memAddr);
  end
  always @(posedge clk) begin
    #1;
    if (p_rd)
      memData = {bmem[{p_addr[7:0], 2'd3}], bmem[{p_addr[7:0], 2'd2}],
                 bmem[{p_addr[7:0], 2'd1}], bmem[{p_addr[7:0], 2'd0}]};
    else
      memData = 32'hDEADBEEF;
  end

  // Consumer: a handshake seen at the negedge completes at the next posedge
  always @(negedge clk) begin
    if (!reset && charValid && charReady) rx.push_back(charOut);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_call(input logic [31:0] v, input logic [31:0] a);
    rx.delete();
    rd_addrs.delete();
    syscall = 1'b1;
    v0 = v;
    a0 = a;
  endtask

  // Counts stalled cycles, releases syscall after DONE, waits for the drain
  task automatic finish_call(input string tag, output int sc);
    logic done;
    done = 1'b0;
    sc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (stall) sc++;
      else begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, " completes"}, {31'b0, done}, 32'd1);
    tick();
    syscall = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!charValid) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, " drains"}, {31'b0, done}, 32'd1);
    tick();
  endtask

  task automatic exp_int(input logic [31:0] a, output int dsum);
    string s;
    logic [31:0] m;
    s = $sformatf("%0d", $signed(a));
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (NLC == 1) exp_q.push_back(8'h0A);
    m = a[31] ? (32'd0 - a) : a;
    dsum = 0;
    while (m != 0) begin
      dsum += int'(m % 10);
      m = m / 10;
    end
  endtask

  // Returns the number of payload bytes (where the walk stopped)
  task automatic exp_str(input int a, output int n);
    exp_q.delete();
    n = 0;
    while (n < MAXS && bmem[a + n] != 8'h00) begin
      exp_q.push_back(bmem[a + n]);
      n++;
    end
    if (NLC == 1) exp_q.push_back(8'h0A);
  endtask

  task automatic check_out(input string tag);
    int n;
    chk({tag, " length"}, rx.size(), exp_q.size());
    n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s byte%0d", tag, i), {24'b0, rx[i]}, {24'b0, exp_q[i]});
  endtask

  task automatic check_reads(input string tag, input int a, input int n);
    int nw;
    nw = ((a + n) >> 2) - (a >> 2) + 1;
    chk({tag, " reads"}, rd_addrs.size(), nw);
    for (int k = 0; k < rd_addrs.size() && k < nw; k++)
      chk($sformatf("%s addr%0d", tag, k), rd_addrs[k], 32'((a >> 2) + k));
  endtask

  task automatic run_int(input string tag, input logic [31:0] a);
    int sc, ds;
    start_call(32'd1, a);
    finish_call(tag, sc);
    exp_int(a, ds);
    check_out(tag);
    chk({tag, " stall cycles"}, sc, 12 + ds + NLC);
  endtask

  task automatic run_str(input string tag, input int a);
    int sc, n;
    start_call(32'd4, a);
    finish_call(tag, sc);
    exp_str(a, n);
    check_out(tag);
    check_reads(tag, a, n);
  endtask

  task automatic run_char(input string tag, input logic [7:0] c);
    int sc;
    start_call(32'd11, {24'b0, c});
    finish_call(tag, sc);
    exp_q.delete();
    exp_q.push_back(c);
    if (NLC == 1) exp_q.push_back(8'h0A);
    check_out(tag);
    chk({tag, " stall cycles"}, sc, 2 + NLC);
  endtask

  initial begin
    int a, len;
    logic [31:0] r;
    reset = 1'b1;
    syscall = 1'b0;
    v0 = '0;
    a0 = '0;
    charReady = 1'b1;
    for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;

    // Reset values
    tick();
    tick();
    @(negedge clk);
    chk("rst stall", {31'b0, stall}, 32'd0);
    chk("rst memRead", {31'b0, memRead}, 32'd0);
    chk("rst memAddr", memAddr, 32'd0);
    chk("rst charValid", {31'b0, charValid}, 32'd0);
    chk("rst charOut", {24'b0, charOut}, 32'd0);
    chk("rst exitReq", {31'b0, exitReq}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // print_int directed and random
    run_int("int123", 32'd123);
    run_int("intmin", 32'h80000000);
    run_int("int0", 32'd0);
    run_int("intmax", 32'h7FFFFFFF);
    for (int i = 0; i < 9; i++) begin
      case (i % 3)
        0:       r = $urandom_range(0, 999);
        1:       r = 32'd0 - 32'($urandom_range(1, 999));
        default: r = $urandom;
      endcase
      run_int($sformatf("intrnd%0d", i), r);
    end

    // print_string "Hi" from word 0x10
    bmem[32'h40] = 8'h48;
    bmem[32'h41] = 8'h69;
    bmem[32'h42] = 8'h00;
    bmem[32'h43] = 8'h00;
    run_str("strHi", 32'h40);

    // Random strings, arbitrary alignment
    for (int i = 0; i < 6; i++) begin
      a = 32'h380 + $urandom_range(0, 7);
      len = $urandom_range(0, 30);
      for (int k = 0; k < len; k++) bmem[a + k] = 8'($urandom_range(1, 255));
      bmem[a + len] = 8'h00;
      run_str($sformatf("strrnd%0d", i), a);
    end

    // Back-pressure: 20-byte string with the consumer stalled
    for (int k = 0; k < 20; k++) bmem[32'h100 + k] = 8'h61 + 8'(k);
    bmem[32'h114] = 8'h00;
    charReady = 1'b0;
    start_call(32'd4, 32'h100);
    repeat (60) tick();
    @(negedge clk);
    chk("bp stall held", {31'b0, stall}, 32'd1);
    chk("bp charValid", {31'b0, charValid}, 32'd1);
    chk("bp head", {24'b0, charOut}, 32'h61);
    chk("bp memRead idle", {31'b0, memRead}, 32'd0);
    chk("bp reads so far", rd_addrs.size(), 32'd3);
    chk("bp nothing taken", rx.size(), 32'd0);
    repeat (20) tick();
    @(negedge clk);
    chk("bp frozen reads", rd_addrs.size(), 32'd3);
    tick();
    charReady = 1'b1;
    begin
      int sc, n;
      finish_call("bp", sc);
      exp_str(32'h100, n);
      check_out("bp");
      check_reads("bp", 32'h100, n);
    end

    // Length limit: 300 non-NUL bytes
    for (int k = 0; k < 300; k++) bmem[32'h200 + k] = 8'h20 + 8'(k % 90);
    bmem[32'h200 + 300] = 8'h00;
    run_str("maxstr", 32'h200);

    // print_char
    run_char("charA", 8'h41);

    // Unsupported service code is ignored
    start_call(32'd5, 32'd77);
    @(negedge clk);
    chk("ign stall", {31'b0, stall}, 32'd0);
    chk("ign memRead", {31'b0, memRead}, 32'd0);
    tick();
    syscall = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("ign charValid", {31'b0, charValid}, 32'd0);
    chk("ign no output", rx.size(), 32'd0);
    tick();

    // Exit request
    start_call(32'd10, 32'd0);
    @(negedge clk);
    chk("exit before edge", {31'b0, exitReq}, 32'd0);
    chk("exit stall", {31'b0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("exit set", {31'b0, exitReq}, 32'd1);
    chk("exit done no stall", {31'b0, stall}, 32'd0);
    tick();
    syscall = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("exit sticky", {31'b0, exitReq}, 32'd1);
    tick();
    run_char("charB after exit", 8'h42);
    @(negedge clk);
    chk("exit still set", {31'b0, exitReq}, 32'd1);
    tick();

    // Reset in the middle of print_int with queued characters
    charReady = 1'b0;
    start_call(32'd1, 32'd987654321);
    repeat (25) tick();
    @(negedge clk);
    chk("mid busy", {31'b0, stall}, 32'd1);
    chk("mid queued", {31'b0, charValid}, 32'd1);
    tick();
    reset = 1'b1;
    syscall = 1'b0;
    tick();
    @(negedge clk);
    chk("mrst stall", {31'b0, stall}, 32'd0);
    chk("mrst memRead", {31'b0, memRead}, 32'd0);
    chk("mrst memAddr", memAddr, 32'd0);
    chk("mrst charValid", {31'b0, charValid}, 32'd0);
    chk("mrst charOut", {24'b0, charOut}, 32'd0);
    chk("mrst exitReq", {31'b0, exitReq}, 32'd0);
    tick();
    reset = 1'b0;
    charReady = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("mrst fifo empty", {31'b0, charValid}, 32'd0);
    chk("mrst nothing out", rx.size(), 32'd0);
    tick();
    run_int("int after reset", 32'd0 - 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
